// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the 32 x 16-bit register file write port between
// the ALU writeback (requester 0) and the load-return path (requester 1).
module regfile_wb_arbiter #(
  parameter bit ZERO_RO = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hold,
  input  logic        req0_valid,
  input  logic [4:0]  req0_idx,
  input  logic [15:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_idx,
  input  logic [15:0] req1_data,
  output logic        req1_ready,
  output logic        rf_w_en,
  output logic [4:0]  rf_w_idx,
  output logic [15:0] rf_w_data,
  output logic        last_grant
);

  // Handshake: a beat moves on requester n at a rising edge where
  // reqn_valid && reqn_ready. Ready is a pure function of hold, both valids,
  // last_grant and reset; valid must never wait on ready, and once raised the
  // requester keeps valid/idx/data stable until its beat is accepted.
  logic        xfer;
  logic        sel;
  logic [4:0]  sel_idx;
  logic [15:0] sel_data;

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (reset && !hold) begin
      if (req0_valid && req1_valid) begin
        // Contended: the requester that did not win last time goes next.
        if (last_grant) req0_ready = 1'b1;
        else            req1_ready = 1'b1;
      end else if (req0_valid) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end
    end
  end

  always_comb begin
    xfer     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
    sel      = req1_ready;
    sel_idx  = sel ? req1_idx  : req0_idx;
    sel_data = sel ? req1_data : req0_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_w_en    <= 1'b0;
      rf_w_idx   <= 5'd0;
      rf_w_data  <= 16'd0;
      last_grant <= 1'b1;
    end else begin
      // r0 writes still complete the handshake but never reach the file.
      rf_w_en <= xfer && !(ZERO_RO && (sel_idx == 5'd0));
      if (xfer) begin
        rf_w_idx   <= sel_idx;
        rf_w_data  <= sel_data;
        last_grant <= sel;
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: per-requester beat queues drive stimulus, a
// reference grant model pushes expected writes, outputs are popped and compared.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        reset;
  logic        hold;
  logic        req0_valid;
  logic [4:0]  req0_idx;
  logic [15:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [4:0]  req1_idx;
  logic [15:0] req1_data;
  logic        req1_ready;
  logic        rf_w_en;
  logic [4:0]  rf_w_idx;
  logic [15:0] rf_w_data;
  logic        last_grant;

  // Second instance with r0 writable, sharing all inputs.
  logic        b_req0_ready;
  logic        b_req1_ready;
  logic        b_rf_w_en;
  logic [4:0]  b_rf_w_idx;
  logic [15:0] b_rf_w_data;
  logic        b_last_grant;

  regfile_wb_arbiter #(.ZERO_RO(1'b1)) dut (
    .clk(clk), .reset(reset), .hold(hold),
    .req0_valid(req0_valid), .req0_idx(req0_idx), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_idx(req1_idx), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_w_en(rf_w_en), .rf_w_idx(rf_w_idx), .rf_w_data(rf_w_data), .last_grant(last_grant)
  );

  regfile_wb_arbiter #(.ZERO_RO(1'b0)) dut_b (
    .clk(clk), .reset(reset), .hold(hold),
    .req0_valid(req0_valid), .req0_idx(req0_idx), .req0_data(req0_data), .req0_ready(b_req0_ready),
    .req1_valid(req1_valid), .req1_idx(req1_idx), .req1_data(req1_data), .req1_ready(b_req1_ready),
    .rf_w_en(b_rf_w_en), .rf_w_idx(b_rf_w_idx), .rf_w_data(b_rf_w_data), .last_grant(b_last_grant)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- scoreboard state ----------------
  // exp_q entry: {en_ro0, en_ro1, idx[4:0], data[15:0]}
  logic [22:0] exp_q[$];
  logic [20:0] q0[$];
  logic [20:0] q1[$];
  logic        m_last;
  logic [4:0]  m_idx;
  logic [15:0] m_data;
  logic [15:0] rf_model [32];
  int          n_cmp;
  int          n_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    logic [22:0] e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check("rf_w_en",     {31'd0, rf_w_en},   {31'd0, e[21]});
      check("rf_w_idx",    {27'd0, rf_w_idx},  {27'd0, e[20:16]});
      check("rf_w_data",   {16'd0, rf_w_data}, {16'd0, e[15:0]});
      check("b_rf_w_en",   {31'd0, b_rf_w_en}, {31'd0, e[22]});
      check("b_rf_w_idx",  {27'd0, b_rf_w_idx},  {27'd0, e[20:16]});
      check("b_rf_w_data", {16'd0, b_rf_w_data}, {16'd0, e[15:0]});
    end
    if (rf_w_en) rf_model[rf_w_idx] = rf_w_data;
  endtask

  // ---------------- driver ----------------
  // Entered just after a rising edge; leaves just after the next one.
  task automatic cycle();
    logic m_r0;
    logic m_r1;
    logic [20:0] b;
    req0_valid = (q0.size() != 0);
    req1_valid = (q1.size() != 0);
    if (req0_valid) {req0_idx, req0_data} = q0[0];
    if (req1_valid) {req1_idx, req1_data} = q1[0];
    @(negedge clk);
    m_r0 = 1'b0;
    m_r1 = 1'b0;
    if (reset && !hold) begin
      if (req0_valid && req1_valid) begin
        if (m_last) m_r0 = 1'b1;
        else        m_r1 = 1'b1;
      end else if (req0_valid) m_r0 = 1'b1;
      else if (req1_valid)     m_r1 = 1'b1;
    end
    check("req0_ready", {31'd0, req0_ready}, {31'd0, m_r0});
    check("req1_ready", {31'd0, req1_ready}, {31'd0, m_r1});
    check("b_req1_ready", {31'd0, b_req1_ready}, {31'd0, m_r1});
    check("last_grant", {31'd0, last_grant}, {31'd0, m_last});
    check_outputs();
    @(posedge clk);
    #1;
    if (!reset) begin
      m_last = 1'b1;
      m_idx  = 5'd0;
      m_data = 16'd0;
      exp_q.push_back(23'd0);
    end else if (m_r0 || m_r1) begin
      b = m_r0 ? q0.pop_front() : q1.pop_front();
      m_last = m_r1;
      {m_idx, m_data} = b;
      exp_q.push_back({1'b1, (b[20:16] != 5'd0), b});
    end else begin
      exp_q.push_back({2'b00, m_idx, m_data});
    end
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < bound) begin
      cycle();
      n++;
    end
    check("drain_timeout", q0.size() + q1.size(), 32'd0);
    cycle();
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    #1;
    exp_q.delete();
    exp_q.push_back(23'd0);
    m_last = 1'b1;
    m_idx  = 5'd0;
    m_data = 16'd0;
  endtask

  // ---------------- tests ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    hold = 1'b0;
    req0_valid = 1'b0; req0_idx = '0; req0_data = '0;
    req1_valid = 1'b0; req1_idx = '0; req1_data = '0;
    for (int i = 0; i < 32; i++) rf_model[i] = 16'd0;
    reset = 1'b0;
    m_last = 1'b1;
    m_idx = 5'd0;
    m_data = 16'd0;
    exp_q.push_back(23'd0);
    @(posedge clk);
    #1;

    // Reset values with both requesters valid, then release.
    q0.push_back({5'd5, 16'h1234});
    q1.push_back({5'd6, 16'h5678});
    cycle();
    cycle();
    reset = 1'b1;
    drain(10);

    // Single requester streaming on req1.
    q1.push_back({5'd3, 16'h1111});
    q1.push_back({5'd4, 16'h2222});
    q1.push_back({5'd5, 16'h3333});
    drain(10);

    // Contention alternation.
    for (int i = 0; i < 4; i++) begin
      q0.push_back({5'd7, 16'hA0A0});
      q1.push_back({5'd9, 16'hB0B0});
    end
    drain(20);

    // Zero register: suppressed only when read-only.
    q0.push_back({5'd0, 16'hFFFF});
    drain(5);

    // Hold with both requesters targeting r12; req1 wins last first.
    q1.push_back({5'd1, 16'hC3C3});
    drain(5);
    hold = 1'b1;
    q0.push_back({5'd12, 16'h0001});
    q1.push_back({5'd12, 16'h0002});
    cycle();
    cycle();
    hold = 1'b0;
    drain(10);
    check("r12_final", {16'd0, rf_model[12]}, 32'h0000_0002);

    // Reset one cycle after a transfer; the pending beat survives.
    q0.push_back({5'd10, 16'h5A5A});
    q0.push_back({5'd11, 16'hA5A5});
    cycle();
    assert_reset();
    cycle();
    reset = 1'b1;
    drain(10);
    check("r10_dropped", {16'd0, rf_model[10]}, 32'h0000_0000);
    check("r11_written", {16'd0, rf_model[11]}, 32'h0000_A5A5);

    // Random traffic with random hold.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 2) == 0 && q0.size() < 3)
        q0.push_back({5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535))});
      if ($urandom_range(0, 2) == 0 && q1.size() < 3)
        q1.push_back({5'($urandom_range(0, 31)), 16'($urandom_range(0, 65535))});
      hold = ($urandom_range(0, 3) == 0);
      cycle();
    end
    hold = 1'b0;
    drain(50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
